// File: rtl/arm_pkg.sv
// Shared definitions for the fetch front end: state encoding, default widths,
// the NOP encoding and a small occupancy helper.
package arm_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int INSTR_W_DEF = 32;

    typedef logic [1:0] state_t;

    localparam state_t S_REQ   = 2'd0;
    localparam state_t S_IDLE  = 2'd1;
    localparam state_t S_FLUSH = 2'd2;

    // mov r0, r0
    localparam logic [INSTR_W_DEF-1:0] NOP_INSTR = 32'hE1A0_0000;

    // Occupancy of the two-entry buffer after one edge of pop/push.
    function automatic logic [1:0] next_occ(input logic [1:0] occ,
                                            input logic       pop,
                                            input logic       push);
        logic [1:0] res;
        res = occ;
        if (pop)  res = res - 2'd1;
        if (push) res = res + 2'd1;
        return res;
    endfunction

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Instruction-memory request/acknowledge bus between the fetch sequencer and memory.
interface if_fetch_ctrl_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
) ();

    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_skid_buf.sv
// Two-entry in-order buffer (head + skid) holding {pc, instruction} words
// returned by memory until the ID side consumes them.
module fetch_skid_buf #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic         head_valid,
    output logic [W-1:0] head_data,
    output logic [1:0]   occ
);

    logic         head_v;
    logic         skid_v;
    logic [W-1:0] head_q;
    logic [W-1:0] skid_q;

    // NOTE: the data registers are reset too, because the head word drives
    // instr_out/pc_out directly and those must read zero during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_v <= 1'b0;
            skid_v <= 1'b0;
            head_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            head_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (pop) begin
            if (skid_v) begin
                head_q <= skid_q;
                head_v <= 1'b1;
                skid_v <= push;
                if (push) skid_q <= din;
            end else begin
                head_v <= push;
                if (push) head_q <= din;
            end
        end else if (push) begin
            if (!head_v) begin
                head_q <= din;
                head_v <= 1'b1;
            end else begin
                skid_q <= din;
                skid_v <= 1'b1;
            end
        end
    end

    assign head_valid = head_v;
    assign head_data  = head_q;
    assign occ        = {head_v & skid_v, head_v ^ skid_v};

endmodule

// File: rtl/if_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues one memory request per instruction,
// buffers up to two returned words and squashes in-flight fetches on redirects.
module if_fetch_ctrl
    import arm_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                INSTR_W  = INSTR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               freeze,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_addr,
    if_fetch_ctrl_if.master    imem,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  pc_out
);

    localparam int W = ADDR_W + INSTR_W;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   fetch_pc;
    logic [ADDR_W-1:0]   flush_addr;
    logic [ADDR_W-1:0]   target_pc;
    logic                req_live;
    logic                acked;
    logic                consume;
    logic                push;
    logic [1:0]          occ;
    logic [W-1:0]        head_data;
    logic                unused_baddr_lsb;

    assign target_pc        = {branch_addr[ADDR_W-1:2], 2'b00};
    assign unused_baddr_lsb = ^branch_addr[1:0];

    // Reset holds the request low even though the state register already reads REQ.
    assign req_live = rst_n && (state != S_IDLE);
    assign acked    = req_live && imem.imem_ack;
    assign consume  = instr_valid && !freeze;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_REQ;
        else        state <= state_nxt;
    end

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        if (branch_taken) begin
            state_nxt = (req_live && !imem.imem_ack) ? S_FLUSH : S_REQ;
        end else begin
            case (state)
                S_REQ:   if (acked && next_occ(occ, consume, 1'b1) == 2'd2) state_nxt = S_IDLE;
                S_IDLE:  if (consume) state_nxt = S_REQ;
                S_FLUSH: if (acked) state_nxt = S_REQ;
                default: state_nxt = S_REQ;
            endcase
        end
    end

    always_comb begin
        imem.imem_req  = req_live;
        imem.imem_addr = (state == S_FLUSH) ? flush_addr : fetch_pc;
        push           = (state == S_REQ) && acked && !branch_taken;
    end

    // flush_addr captures the squashed address only on REQ->FLUSH, so a second
    // branch during FLUSH leaves the outstanding request untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc   <= RESET_PC;
            flush_addr <= '0;
        end else if (branch_taken) begin
            fetch_pc <= target_pc;
            if (state == S_REQ && !imem.imem_ack) flush_addr <= fetch_pc;
        end else if (push) begin
            fetch_pc <= fetch_pc + ADDR_W'(4);
        end
    end

    fetch_skid_buf #(.W(W)) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .pop        (consume),
        .flush      (branch_taken),
        .din        ({fetch_pc, imem.imem_rdata}),
        .head_valid (instr_valid),
        .head_data  (head_data),
        .occ        (occ)
    );

    assign pc_out    = head_data[W-1 -: ADDR_W];
    assign instr_out = head_data[INSTR_W-1:0];

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed, table-driven bench for if_fetch_ctrl with a variable-latency memory model.
module tb_if_fetch_ctrl;
    import arm_pkg::*;

    typedef struct {
        bit          rst;
        int          lat;
        bit          frz;
        bit          br;
        logic [31:0] baddr;
        bit          inj;
        bit          ev;
        logic [31:0] epc;
        bit          ereq;
        logic [31:0] eaddr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [31:0] pc_out;

    int          lat;
    logic        ack_inj;
    logic [3:0]  wcnt;
    int          n_vec;
    int          n_miss;
    vec_t        vq[$];

    if_fetch_ctrl_if #(.ADDR_W(32), .INSTR_W(32)) bus ();

    if_fetch_ctrl #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem         (bus.master),
        .instr_valid  (instr_valid),
        .instr_out    (instr_out),
        .pc_out       (pc_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 | {16'h0, a[17:2]};
    endfunction

    // Memory acks once the request has waited lat cycles; ack_inj forces a stray ack.
    assign bus.imem_ack   = (bus.imem_req && (int'(wcnt) >= lat)) || ack_inj;
    assign bus.imem_rdata = bus.imem_ack ? mem_word(bus.imem_addr) : NOP_INSTR;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           wcnt <= '0;
        else if (bus.imem_req && bus.imem_ack) wcnt <= '0;
        else if (bus.imem_req)                 wcnt <= wcnt + 4'd1;
        else                                   wcnt <= '0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input bit rst, input int l, input bit frz, input bit br,
                       input logic [31:0] ba, input bit inj, input bit ev,
                       input logic [31:0] epc, input bit ereq, input logic [31:0] eaddr);
        vec_t v;
        v = '{rst, l, frz, br, ba, inj, ev, epc, ereq, eaddr};
        vq.push_back(v);
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        freeze       = 1'b0;
        branch_taken = 1'b0;
        ack_inj      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_vec  = 0;
        n_miss = 0;
        lat    = 0;
        rst_n  = 1'b1;
        freeze = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = '0;
        ack_inj      = 1'b0;

        // zero-wait streaming
        add(1,0,0,0,0,0, 1,32'h0, 1,32'h4);
        add(0,0,0,0,0,0, 1,32'h4, 1,32'h8);
        add(0,0,0,0,0,0, 1,32'h8, 1,32'hC);
        add(0,0,0,0,0,0, 1,32'hC, 1,32'h10);
        // three wait states
        add(1,3,0,0,0,0, 0,32'h0, 1,32'h0);
        add(0,3,0,0,0,0, 0,32'h0, 1,32'h0);
        add(0,3,0,0,0,0, 0,32'h0, 1,32'h0);
        add(0,3,0,0,0,0, 1,32'h0, 1,32'h4);
        add(0,3,0,0,0,0, 0,32'h0, 1,32'h4);
        add(0,3,0,0,0,0, 0,32'h0, 1,32'h4);
        add(0,3,0,0,0,0, 0,32'h0, 1,32'h4);
        add(0,3,0,0,0,0, 1,32'h4, 1,32'h8);
        // freeze for five cycles, stray ack while idle, then release
        add(1,0,1,0,0,0, 1,32'h0, 1,32'h4);
        add(0,0,1,0,0,0, 1,32'h0, 0,32'h8);
        add(0,0,1,0,0,0, 1,32'h0, 0,32'h8);
        add(0,0,1,0,0,1, 1,32'h0, 0,32'h8);
        add(0,0,1,0,0,0, 1,32'h0, 0,32'h8);
        add(0,0,0,0,0,0, 1,32'h4, 1,32'h8);
        add(0,0,0,0,0,0, 1,32'h8, 1,32'hC);
        add(0,0,0,0,0,0, 1,32'hC, 1,32'h10);
        // redirect while a 2-wait request to 0x10 is pending
        add(1,0,0,0,0,0, 1,32'h0, 1,32'h4);
        add(0,0,0,0,0,0, 1,32'h4, 1,32'h8);
        add(0,0,0,0,0,0, 1,32'h8, 1,32'hC);
        add(0,0,0,0,0,0, 1,32'hC, 1,32'h10);
        add(0,2,0,0,0,0, 0,32'h0, 1,32'h10);
        add(0,2,0,1,32'h40,0, 0,32'h0, 1,32'h10);
        add(0,2,0,0,0,0, 0,32'h0, 1,32'h40);
        add(0,2,0,0,0,0, 0,32'h0, 1,32'h40);
        add(0,2,0,0,0,0, 0,32'h0, 1,32'h40);
        add(0,2,0,0,0,0, 1,32'h40, 1,32'h44);
        // branch together with ack under freeze, then branch with two buffered
        add(1,0,1,0,0,0, 1,32'h0, 1,32'h4);
        add(0,0,1,1,32'h80,0, 0,32'h0, 1,32'h80);
        add(0,0,1,0,0,0, 1,32'h80, 1,32'h84);
        add(0,0,1,0,0,0, 1,32'h80, 0,32'h88);
        add(0,0,1,1,32'h100,0, 0,32'h0, 1,32'h100);
        add(0,0,0,0,0,0, 1,32'h100, 1,32'h104);
        // fetch_pc wrap-around, low target bits ignored
        add(1,0,0,1,32'hFFFF_FFFE,0, 0,32'h0, 1,32'hFFFF_FFFC);
        add(0,0,0,0,0,0, 1,32'hFFFF_FFFC, 1,32'h0);
        add(0,0,0,0,0,0, 1,32'h0, 1,32'h4);

        // reset values while rst_n is low
        rst_n = 1'b0;
        #3;
        check("reset valid", {31'h0, instr_valid}, 32'h0);
        check("reset instr", instr_out, 32'h0);
        check("reset pc",    pc_out, 32'h0);
        check("reset req",   {31'h0, bus.imem_req}, 32'h0);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            if (vq[i].rst) do_reset();
            lat          = vq[i].lat;
            freeze       = vq[i].frz;
            branch_taken = vq[i].br;
            branch_addr  = vq[i].baddr;
            ack_inj      = vq[i].inj;
            @(posedge clk);
            #1;
            check($sformatf("v%0d valid", i), {31'h0, instr_valid}, {31'h0, vq[i].ev});
            check($sformatf("v%0d req", i),   {31'h0, bus.imem_req}, {31'h0, vq[i].ereq});
            check($sformatf("v%0d addr", i),  bus.imem_addr, vq[i].eaddr);
            if (vq[i].ev) begin
                check($sformatf("v%0d pc", i),    pc_out, vq[i].epc);
                check($sformatf("v%0d instr", i), instr_out, mem_word(vq[i].epc));
            end
        end

        // reset asserted in the middle of an outstanding request
        @(negedge clk);
        do_reset();
        lat = 0;
        @(posedge clk);
        #1;
        check("mid pc0", pc_out, 32'h0);
        @(negedge clk);
        lat = 3;
        @(posedge clk);
        #1;
        check("mid pending addr", bus.imem_addr, 32'h4);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid rst valid", {31'h0, instr_valid}, 32'h0);
        check("mid rst instr", instr_out, 32'h0);
        check("mid rst pc",    pc_out, 32'h0);
        check("mid rst req",   {31'h0, bus.imem_req}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n        = 1'b1;
        lat          = 0;
        branch_taken = 1'b1;
        branch_addr  = 32'h43;
        #1;
        check("post rst req",  {31'h0, bus.imem_req}, 32'h1);
        check("post rst addr", bus.imem_addr, 32'h0);
        @(posedge clk);
        #1;
        check("br43 valid", {31'h0, instr_valid}, 32'h0);
        check("br43 addr",  bus.imem_addr, 32'h40);
        @(negedge clk);
        branch_taken = 1'b0;
        @(posedge clk);
        #1;
        check("br43 pc",    pc_out, 32'h40);
        check("br43 instr", instr_out, mem_word(32'h40));
        check("br43 next",  bus.imem_addr, 32'h44);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
